// File: rtl/dff_mem_host_pkg.sv
// Shared types and helpers for the DFF memory host sequencer.
// Holds the march FSM encoding, default sizes and the test pattern.
package dff_mem_host_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    W0    = 4'd1,
    R0_RD = 4'd2,
    R0_WT = 4'd3,
    R0_CW = 4'd4,
    R1_RD = 4'd5,
    R1_WT = 4'd6,
    R1_CK = 4'd7,
    DONE  = 4'd8
  } state_t;

  function automatic logic [31:0] pat(
    input logic [31:0] seed,
    input logic [31:0] addr,
    input logic        inv
  );
    pat = (seed ^ addr) ^ {32{inv}};
  endfunction

endpackage

// File: rtl/dff_mem_host_chk.sv
// Read-data checker: mismatch count, first failing address, pass flag.
// All updates are gated by chk_en; clr wipes the result of the last run.
module dff_mem_host_chk
  import dff_mem_host_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              chk_en,
  input  logic              last,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] rdata,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [7:0]        err_count
);

  logic       miss;
  logic [7:0] cnt_nxt;

  assign miss = chk_en && (rdata != expected);

  assign cnt_nxt = (miss && err_count != 8'hFF)
                 ? err_count + 8'd1
                 : err_count;

  // Accumulate mismatches; pass is settled on the final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (clr) begin
      pass      <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      err_count <= cnt_nxt;
      if (miss && err_count == 8'd0)
        err_addr <= addr;
      if (chk_en && last)
        pass <= (cnt_nxt == 8'd0);
    end
  end

endmodule

// File: rtl/dff_mem_host.sv
// Host-side march sequencer for the DFF register-file memory.
// Write, read-check-invert ascending, read-check descending.
module dff_mem_host
  import dff_mem_host_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] seed_q;
  logic [LW-1:0]     lat;
  logic [DATA_W-1:0] d;
  logic              acc;
  logic              chk_en;
  logic              last;
  logic [DATA_W-1:0] expected;

  assign d = DATA_W'(pat(32'(seed_q), 32'(addr), 1'b0));

  assign acc      = (state == IDLE) && start && ena;
  assign chk_en   = ena && (state == R0_CW || state == R1_CK);
  assign last     = (state == R1_CK) && (addr == '0);
  assign expected = (state == R1_CK) ? ~d : d;

  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign mem_addr = addr;

  // March sequencer: phase, address and read-latency tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      seed_q <= '0;
      lat    <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= W0;
            addr   <= '0;
            seed_q <= seed;
          end
        end
        W0: begin
          if (addr == AMAX) begin
            state <= R0_RD;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        R0_RD: begin
          lat   <= LW'(1);
          state <= (RD_LAT == 1) ? R0_CW : R0_WT;
        end
        R0_WT: begin
          if (lat == LW'(RD_LAT - 1))
            state <= R0_CW;
          else
            lat <= lat + LW'(1);
        end
        R0_CW: begin
          if (addr == AMAX) begin
            state <= R1_RD;
            addr  <= AMAX;
          end else begin
            state <= R0_RD;
            addr  <= addr + 1'b1;
          end
        end
        R1_RD: begin
          lat   <= LW'(1);
          state <= (RD_LAT == 1) ? R1_CK : R1_WT;
        end
        R1_WT: begin
          if (lat == LW'(RD_LAT - 1))
            state <= R1_CK;
          else
            lat <= lat + LW'(1);
        end
        R1_CK: begin
          if (addr == '0) begin
            state <= DONE;
          end else begin
            state <= R1_RD;
            addr  <= addr - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe decode from registered state only; ena low silences the bus.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    if (ena) begin
      unique case (1'b1)
        state == W0: begin
          mem_we    = 1'b1;
          mem_wdata = d;
        end
        state == R0_CW: begin
          mem_we    = 1'b1;
          mem_wdata = ~d;
        end
        state == R0_RD,
        state == R1_RD: mem_re = 1'b1;
        default: ;
      endcase
    end
  end

  dff_mem_host_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc),
    .chk_en    (chk_en),
    .last      (last),
    .addr      (addr),
    .expected  (expected),
    .rdata     (mem_rdata),
    .pass      (pass),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_dff_mem_host.sv
// Bench for dff_mem_host: faulty memory model plus march reference.
// Random seeds, faults and enable gaps around the directed scenarios.
module tb_dff_mem_host;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena   = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed  = '0;
  logic          busy, done, pass;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we, mem_re;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] s0  [N];
  logic [DW-1:0] s1  [N];

  always #5 clk = ~clk;

  dff_mem_host dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_addr  (err_addr),
    .err_count (err_count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] flt(
    input logic [DW-1:0] v,
    input int            a
  );
    return (v & ~s0[a]) | s1[a];
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= flt(mem_wdata, int'(mem_addr));
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      s0[a] = '0;
      s1[a] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_eaddr"}, 32'(err_addr), 0);
    check({tag, "_ecnt"}, 32'(err_count), 0);
    check({tag, "_maddr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_re"}, 32'(mem_re), 0);
  endtask

  task automatic run(
    input logic [7:0] sd,
    input int         lowpct,
    input int         lo_from,
    input int         lo_to,
    input bit         hold,
    input int         abort_at
  );
    int            off, lows, wr_n, wr_bad, strobe_bad;
    int            exp_cnt, exp_ea;
    bit            first;
    logic [DW-1:0] dv, ew;
    logic [AW-1:0] ea;

    exp_cnt = 0;
    exp_ea  = 0;
    first   = 1'b1;
    for (int a = 0; a < N; a++) begin
      dv = sd ^ DW'(a);
      if (flt(dv, a) !== dv) begin
        exp_cnt++;
        if (first) begin exp_ea = a; first = 1'b0; end
      end
    end
    for (int a = N - 1; a >= 0; a--) begin
      dv = ~(sd ^ DW'(a));
      if (flt(dv, a) !== dv) begin
        exp_cnt++;
        if (first) begin exp_ea = a; first = 1'b0; end
      end
    end
    if (exp_cnt > 255) exp_cnt = 255;

    @(posedge clk); #1;
    seed  = sd;
    start = 1'b1;
    ena   = 1'b1;

    off = 1; lows = 0; wr_n = 0; wr_bad = 0; strobe_bad = 0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    #2;
    check("acc_busy", 32'(busy), 1);
    check("acc_ecnt", 32'(err_count), 0);
    check("acc_pass", 32'(pass), 0);

    while (!done && off < 400) begin
      if (mem_we && mem_re) strobe_bad++;
      if (!ena && (mem_we || mem_re)) strobe_bad++;
      if (!ena) lows++;
      if (mem_we) begin
        ea = AW'(wr_n % N);
        ew = (wr_n < N) ? (sd ^ DW'(ea)) : ~(sd ^ DW'(ea));
        if (mem_addr !== ea || mem_wdata !== ew) wr_bad++;
        wr_n++;
      end
      if (lowpct == 0 && lo_from == 0 && off == 4)
        check("w3", {23'd0, mem_we, mem_addr, mem_wdata},
              {23'd0, 1'b1, 4'd3, sd ^ 8'h03});
      if (abort_at != 0 && off == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ena   = 1'b1;
        return;
      end
      @(posedge clk); #1;
      off++;
      ena = !(off >= lo_from && off <= lo_to) &&
            (int'($urandom_range(99)) >= lowpct);
      #2;
    end

    check("done_seen", 32'(done), 1);
    check("run_len", 32'(off - lows), 81);
    check("busy_at_done", 32'(busy), 0);
    check("pass", 32'(pass), 32'(exp_cnt == 0));
    check("err_count", 32'(err_count), 32'(exp_cnt));
    check("err_addr", 32'(err_addr), 32'(exp_ea));
    check("writes", 32'(wr_n), 2 * N);
    check("write_bad", 32'(wr_bad), 0);
    check("strobe_bad", 32'(strobe_bad), 0);
    if (lo_from != 0) check("gap_len", 32'(off), 91);
    ena = 1'b1;

    if (hold) begin
      @(posedge clk); #3;
      check("gap_busy", 32'(busy), 0);
      @(posedge clk); #3;
      check("relaunch_busy", 32'(busy), 1);
      check("relaunch_ecnt", 32'(err_count), 0);
      check("relaunch_pass", 32'(pass), 0);
      start = 1'b0;
      off = 0;
      while (!done && off < 400) begin
        @(posedge clk); #3;
        off++;
      end
      check("relaunch_done", 32'(done), 1);
      check("relaunch_cnt", 32'(err_count), 32'(exp_cnt));
      check("relaunch_res", 32'(pass), 32'(exp_cnt == 0));
    end
  endtask

  initial begin
    int nf, a;
    clear_faults();
    #3;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(8'hA5, 0, 0, 0, 1'b0, 0);

    s0[5] = 8'h01;
    run(8'h00, 0, 0, 0, 1'b0, 0);
    check("sa0_ea", 32'(err_addr), 5);

    clear_faults();
    s1[9] = 8'h80;
    s1[2] = 8'h80;
    run(8'h00, 0, 0, 0, 1'b0, 0);
    check("sa1_cnt", 32'(err_count), 2);

    clear_faults();
    run(8'h3C, 0, 20, 29, 1'b0, 0);

    run(8'h5A, 0, 0, 0, 1'b0, 40);
    run(8'h5A, 0, 0, 0, 1'b0, 0);

    s0[7] = 8'h10;
    run(8'hC3, 0, 0, 0, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = int'($urandom_range(3));
      for (int i = 0; i < nf; i++) begin
        a = int'($urandom_range(N - 1));
        s0[a] = DW'($urandom);
        s1[a] = DW'($urandom) & ~s0[a];
      end
      run(DW'($urandom), 15, 0, 0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
